taxi_dma_rx_slot_alloc: RTL
===========================

Name: taxi_dma_rx_slot_alloc

Overview:
Receive-buffer slot allocator that sits directly upstream of the AXI stream sink DMA client.
- Carves a ring region of DMA RAM into fixed-size slots.
- Issues one write descriptor per free slot to the sink and collects the sink's status responses.
- Presents completed-packet records (address, length, sideband) to a consumer, which returns slots in order when done.
- Keeps the sink continuously primed with buffer space without software per-packet involvement.

Parameters:
RAM_ADDR_W, 16, DMA RAM byte address width
RING_BASE, 0, byte base address of ring in DMA RAM; must be aligned to 2**RING_SIZE_LOG2
RING_SIZE_LOG2, 14, log2 ring size in bytes (16 KiB)
SLOT_SIZE_LOG2, 11, log2 slot size in bytes (2 KiB); NSLOT = 2**(RING_SIZE_LOG2-SLOT_SIZE_LOG2) = 8
OUTSTANDING, 4, max descriptors issued but not yet delivered to consumer; power of two, <= NSLOT
LEN_W, 20, length field width; must satisfy 2**LEN_W > 2**SLOT_SIZE_LOG2
TAG_W, 8, tag width; must be >= log2(NSLOT)
ID_W / DEST_W / USER_W, 8 / 8 / 8, AXI stream sideband widths carried in status

Ports:
Interface conventions: one clock; reset is asynchronous and active-high.
clk  in  1  clock
rst  in  1  async active-high reset
m_desc_dst_addr  out  RAM_ADDR_W  slot base address
m_desc_len  out  LEN_W  always 2**SLOT_SIZE_LOG2
m_desc_tag  out  TAG_W  slot index, zero-extended
m_desc_valid  out  1  descriptor valid
m_desc_ready  in  1  sink accepts descriptor
s_sts_len  in  LEN_W  bytes written
s_sts_tag  in  TAG_W  returned tag
s_sts_id / s_sts_dest / s_sts_user  in  ID_W/DEST_W/USER_W  sideband of the packet
s_sts_error  in  4  sink error code
s_sts_valid  in  1  single-cycle status strobe; no backpressure
m_cmpl_addr  out  RAM_ADDR_W  slot base address
m_cmpl_len  out  LEN_W  bytes written
m_cmpl_id / m_cmpl_dest / m_cmpl_user  out  as above  packet sideband
m_cmpl_error  out  4  sink error code
m_cmpl_valid  out  1  record valid
m_cmpl_ready  in  1  consumer accepts record
s_free_valid  in  1  one-cycle pulse; frees the oldest delivered, unfreed slot
enable  in  1  permits issuing new descriptors
slots_free  out  log2(NSLOT)+1  unallocated slot count
tag_err  out  1  sticky protocol error flag

Behaviour:
- Pointers, each log2(NSLOT)+1 bits, wrapping modulo 2*NSLOT:
  - iss_ptr: descriptors accepted.
  - cmp_ptr: statuses received.
  - dlv_ptr: records handshaken.
  - fre_ptr: slots freed.
- Reset: all pointers = 0, FIFO empty, m_desc_valid = 0, m_cmpl_valid = 0, tag_err = 0, slots_free = NSLOT. All other outputs = 0.
- Issue condition (registered): enable && (iss_ptr-fre_ptr) < NSLOT && (iss_ptr-dlv_ptr) < OUTSTANDING.
  - m_desc_valid rises the cycle after the condition holds.
  - Fields are driven from iss_ptr: dst_addr = RING_BASE + (iss_ptr[idx] << SLOT_SIZE_LOG2), tag = iss_ptr[idx].
  - Once asserted, valid and fields are held stable until m_desc_ready, even if enable falls.
  - On handshake, iss_ptr increments. Valid re-asserts the next cycle only if the condition still holds with the new pointer; no back-to-back issue is required.
- Status handling:
  - On s_sts_valid with cmp_ptr != iss_ptr:
    - if s_sts_tag == cmp_ptr[idx], push record {addr, len, id, dest, user, error} into the completion FIFO and increment cmp_ptr;
    - if the tag mismatches, set tag_err, push nothing, and leave cmp_ptr unchanged.
  - On s_sts_valid with cmp_ptr == iss_ptr: set tag_err and ignore the status.
  - Non-zero error codes are forwarded unchanged; the slot must still be freed by the consumer.
- Completion FIFO: depth OUTSTANDING; cannot overflow by construction of the issue condition.
  - m_cmpl_valid asserts 1 cycle after the push (registered output).
  - A handshake increments dlv_ptr.
- Free: s_free_valid with fre_ptr != dlv_ptr increments fre_ptr. With fre_ptr == dlv_ptr it sets tag_err and is ignored.
- Simultaneous events: issue handshake, status push, cmpl handshake, and free may all occur in the same cycle. Every counter updates independently. FIFO push and pop in the same cycle on a full FIFO is legal.
- slots_free = NSLOT - (iss_ptr - fre_ptr), registered.
- tag_err clears only on reset.
- Reset mid-operation: all state is discarded. Late statuses from pre-reset descriptors hit cmp_ptr == iss_ptr and set tag_err, so the bench must also reset the sink.

Decomposition:
- Package taxi_dma_rx_alloc_pkg holds:
  - the cmpl_rec_t packed struct (addr, len, id, dest, user, error);
  - the sts error code constants;
  - the helper function slot_addr(idx).
- Sub-module taxi_dma_rx_cmpl_fifo: synchronous FIFO of cmpl_rec_t, depth OUTSTANDING, with registered output and a valid/ready pop side.

Test Plan:
- Reset, enable=1, ready=1: descriptors are issued with dst_addr 0x0000, 0x0800, 0x1000, 0x1800 and tags 0-3, then m_desc_valid stays low (OUTSTANDING limit reached). slots_free = 4.
- Statuses for tags 0 and 1 with len 64 and 1500, consumer ready=1: m_cmpl records {0x0000,64} and {0x0800,1500} appear, each one cycle after its status. Two new descriptors are issued at 0x2000 and 0x2800.
- Run 8 packets with no frees: issue stops at slots_free = 0. Then pulse free 3 times: descriptors resume with wrap addresses 0x0000, 0x0800, 0x1000.
- Status with tag 5 while tag 2 is expected: tag_err = 1, no record is produced, and the subsequent correct tag 2 is still accepted.
- Hold m_cmpl_ready=0 while 4 statuses arrive: the FIFO holds all 4 and no descriptor is issued. Release ready: 4 records come out in order, then issue resumes.
- Drop enable while m_desc_valid=1 and ready=0: valid and addr stay held until ready. Afterwards no new issue occurs; assert reset mid-stream and check all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/taxi_dma_rx_alloc_pkg.sv
// Shared types and constants for the RX slot allocator: the completion
// record carried from status to consumer, sink error codes, and the slot
// base address helper. The D_* constants are the default configuration
// and also size the completion record.
package taxi_dma_rx_alloc_pkg;

    localparam int D_RAM_ADDR_W     = 16;
    localparam int D_RING_BASE      = 0;
    localparam int D_RING_SIZE_LOG2 = 14;
    localparam int D_SLOT_SIZE_LOG2 = 11;
    localparam int D_OUTSTANDING    = 4;
    localparam int D_LEN_W          = 20;
    localparam int D_TAG_W          = 8;
    localparam int D_ID_W           = 8;
    localparam int D_DEST_W         = 8;
    localparam int D_USER_W         = 8;

    // Sink status error codes, forwarded to the consumer untouched
    localparam logic [3:0] STS_ERR_NONE         = 4'd0;
    localparam logic [3:0] STS_ERR_TIMEOUT      = 4'd1;
    localparam logic [3:0] STS_ERR_PARITY       = 4'd2;
    localparam logic [3:0] STS_ERR_AXI_SLVERR   = 4'd4;
    localparam logic [3:0] STS_ERR_AXI_DECERR   = 4'd5;
    localparam logic [3:0] STS_ERR_OVERSIZE     = 4'd8;

    typedef struct packed {
        logic [D_RAM_ADDR_W-1:0] addr;
        logic [D_LEN_W-1:0]      len;
        logic [D_ID_W-1:0]       id;
        logic [D_DEST_W-1:0]     dest;
        logic [D_USER_W-1:0]     user;
        logic [3:0]              error;
    } cmpl_rec_t;

    // Byte address of slot idx inside the ring
    function automatic logic [D_RAM_ADDR_W-1:0] slot_addr(
        input logic [D_RAM_ADDR_W-1:0] idx,
        input logic [D_RAM_ADDR_W-1:0] base = D_RAM_ADDR_W'(D_RING_BASE),
        input int                      slot_log2 = D_SLOT_SIZE_LOG2
    );
        return base + (idx << slot_log2);
    endfunction

endpackage

// File: rtl/taxi_dma_rx_cmpl_fifo.sv
// Completion record FIFO with a registered output stage. A record pushed
// into an empty FIFO appears on the output the following cycle. DEPTH must
// be a power of two and at least 2.
module taxi_dma_rx_cmpl_fifo
    import taxi_dma_rx_alloc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  cmpl_rec_t push_rec,
    output cmpl_rec_t pop_rec,
    output logic      pop_valid,
    input  logic      pop_ready
);

    localparam int AW = $clog2(DEPTH);

    cmpl_rec_t   mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        mem_empty;
    logic        load;
    logic        take_mem;
    logic        take_push;
    logic        mem_write;

    // Output stage refills from storage first, else straight from the push
    always_comb begin
        mem_empty = (wr_ptr == rd_ptr);
        load      = !pop_valid || pop_ready;
        take_mem  = load && !mem_empty;
        take_push = load && mem_empty && push;
        mem_write = push && !take_push;
    end

    // Storage array; contents are qualified by the pointers so no reset
    always_ff @(posedge clk) begin
        if (mem_write) begin
            mem[wr_ptr[AW-1:0]] <= push_rec;
        end
    end

    // Pointers and registered output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pop_valid <= 1'b0;
            pop_rec   <= '0;
        end else begin
            if (mem_write) wr_ptr <= wr_ptr + 1'b1;
            if (take_mem)  rd_ptr <= rd_ptr + 1'b1;
            if (load) begin
                pop_valid <= take_mem || take_push;
                if (take_mem) begin
                    pop_rec <= mem[rd_ptr[AW-1:0]];
                end else if (take_push) begin
                    pop_rec <= push_rec;
                end
            end
        end
    end

endmodule

// File: rtl/taxi_dma_rx_slot_alloc.sv
// RX buffer slot allocator: hands fixed-size ring slots to the stream sink
// as write descriptors, matches sink statuses back to slots in order, and
// presents completed packets to a consumer that frees slots in order.
//
// Handshakes: a transfer occurs on a rising clock edge where valid and
// ready are both high; once valid is raised, the payload is held stable
// and valid stays high until that transfer. s_sts_valid and s_free_valid
// are strobes with no ready.
module taxi_dma_rx_slot_alloc
    import taxi_dma_rx_alloc_pkg::*;
#(
    parameter int RAM_ADDR_W     = D_RAM_ADDR_W,
    parameter int RING_BASE      = D_RING_BASE,
    parameter int RING_SIZE_LOG2 = D_RING_SIZE_LOG2,
    parameter int SLOT_SIZE_LOG2 = D_SLOT_SIZE_LOG2,
    parameter int OUTSTANDING    = D_OUTSTANDING,
    parameter int LEN_W          = D_LEN_W,
    parameter int TAG_W          = D_TAG_W,
    parameter int ID_W           = D_ID_W,
    parameter int DEST_W         = D_DEST_W,
    parameter int USER_W         = D_USER_W
) (
    input  logic                                   clk,
    input  logic                                   rst,
    output logic [RAM_ADDR_W-1:0]                  m_desc_dst_addr,
    output logic [LEN_W-1:0]                       m_desc_len,
    output logic [TAG_W-1:0]                       m_desc_tag,
    output logic                                   m_desc_valid,
    input  logic                                   m_desc_ready,
    input  logic [LEN_W-1:0]                       s_sts_len,
    input  logic [TAG_W-1:0]                       s_sts_tag,
    input  logic [ID_W-1:0]                        s_sts_id,
    input  logic [DEST_W-1:0]                      s_sts_dest,
    input  logic [USER_W-1:0]                      s_sts_user,
    input  logic [3:0]                             s_sts_error,
    input  logic                                   s_sts_valid,
    output logic [RAM_ADDR_W-1:0]                  m_cmpl_addr,
    output logic [LEN_W-1:0]                       m_cmpl_len,
    output logic [ID_W-1:0]                        m_cmpl_id,
    output logic [DEST_W-1:0]                      m_cmpl_dest,
    output logic [USER_W-1:0]                      m_cmpl_user,
    output logic [3:0]                             m_cmpl_error,
    output logic                                   m_cmpl_valid,
    input  logic                                   m_cmpl_ready,
    input  logic                                   s_free_valid,
    input  logic                                   enable,
    output logic [RING_SIZE_LOG2-SLOT_SIZE_LOG2:0] slots_free,
    output logic                                   tag_err
);

    localparam int NSLOT = 2 ** (RING_SIZE_LOG2 - SLOT_SIZE_LOG2);
    localparam int IDX_W = RING_SIZE_LOG2 - SLOT_SIZE_LOG2;
    localparam int PTR_W = IDX_W + 1;

    // Ring pointers wrap modulo 2*NSLOT so full and empty are distinguishable
    logic [PTR_W-1:0] iss_ptr, cmp_ptr, dlv_ptr, fre_ptr;
    logic [PTR_W-1:0] iss_nxt, cmp_nxt, dlv_nxt, fre_nxt;
    logic [PTR_W-1:0] slots_free_nxt;
    logic             desc_valid_nxt, tag_err_nxt;
    logic             issue_ok, desc_hs, cmpl_hs;
    logic             sts_pending, sts_match, sts_push, sts_bad;
    logic             free_ok, free_bad;
    cmpl_rec_t        push_rec, pop_rec;

    // Event decode and independent next-pointer computation
    always_comb begin
        issue_ok    = enable
                      && ((iss_ptr - fre_ptr) < PTR_W'(NSLOT))
                      && ((iss_ptr - dlv_ptr) < PTR_W'(OUTSTANDING));
        desc_hs     = m_desc_valid && m_desc_ready;
        cmpl_hs     = m_cmpl_valid && m_cmpl_ready;
        sts_pending = (cmp_ptr != iss_ptr);
        sts_match   = (s_sts_tag == TAG_W'(cmp_ptr[IDX_W-1:0]));
        sts_push    = s_sts_valid && sts_pending && sts_match;
        sts_bad     = s_sts_valid && !(sts_pending && sts_match);
        free_ok     = s_free_valid && (fre_ptr != dlv_ptr);
        free_bad    = s_free_valid && (fre_ptr == dlv_ptr);

        iss_nxt = desc_hs  ? iss_ptr + 1'b1 : iss_ptr;
        cmp_nxt = sts_push ? cmp_ptr + 1'b1 : cmp_ptr;
        dlv_nxt = cmpl_hs  ? dlv_ptr + 1'b1 : dlv_ptr;
        fre_nxt = free_ok  ? fre_ptr + 1'b1 : fre_ptr;

        // Valid drops for one cycle after each accept, then re-evaluates
        desc_valid_nxt = m_desc_valid ? !desc_hs : issue_ok;
        tag_err_nxt    = tag_err || sts_bad || free_bad;
        slots_free_nxt = PTR_W'(NSLOT) - (iss_nxt - fre_nxt);
    end

    // Completion record for the slot the sink has just reported on
    always_comb begin
        push_rec       = '0;
        push_rec.addr  = slot_addr(RAM_ADDR_W'(cmp_ptr[IDX_W-1:0]),
                                   RAM_ADDR_W'(RING_BASE), SLOT_SIZE_LOG2);
        push_rec.len   = s_sts_len;
        push_rec.id    = s_sts_id;
        push_rec.dest  = s_sts_dest;
        push_rec.user  = s_sts_user;
        push_rec.error = s_sts_error;
    end

    // Pointer, descriptor-valid, status-flag and free-count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_ptr      <= '0;
            cmp_ptr      <= '0;
            dlv_ptr      <= '0;
            fre_ptr      <= '0;
            m_desc_valid <= 1'b0;
            tag_err      <= 1'b0;
            slots_free   <= PTR_W'(NSLOT);
        end else begin
            iss_ptr      <= iss_nxt;
            cmp_ptr      <= cmp_nxt;
            dlv_ptr      <= dlv_nxt;
            fre_ptr      <= fre_nxt;
            m_desc_valid <= desc_valid_nxt;
            tag_err      <= tag_err_nxt;
            slots_free   <= slots_free_nxt;
        end
    end

    // Descriptor fields follow iss_ptr, which cannot move while valid waits
    assign m_desc_dst_addr = slot_addr(RAM_ADDR_W'(iss_ptr[IDX_W-1:0]),
                                       RAM_ADDR_W'(RING_BASE), SLOT_SIZE_LOG2);
    assign m_desc_len      = LEN_W'(2 ** SLOT_SIZE_LOG2);
    assign m_desc_tag      = TAG_W'(iss_ptr[IDX_W-1:0]);

    taxi_dma_rx_cmpl_fifo #(
        .DEPTH(OUTSTANDING)
    ) u_cmpl_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (sts_push),
        .push_rec (push_rec),
        .pop_rec  (pop_rec),
        .pop_valid(m_cmpl_valid),
        .pop_ready(m_cmpl_ready)
    );

    assign m_cmpl_addr  = pop_rec.addr;
    assign m_cmpl_len   = pop_rec.len;
    assign m_cmpl_id    = pop_rec.id;
    assign m_cmpl_dest  = pop_rec.dest;
    assign m_cmpl_user  = pop_rec.user;
    assign m_cmpl_error = pop_rec.error;

endmodule
